// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: one outstanding memory read at a time feeding a
// 2-entry in-order prefetch FIFO, with branch redirect and stale-response discard.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'hE0000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_rd_en,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] Instruction_out,
   output logic        out_valid,
   output logic [1:0]  buf_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state_reg;
   logic [31:0] fetch_pc_reg;
   logic [31:0] req_addr_reg;
   logic [1:0]  count_reg;
   logic        rd_ptr_reg;
   logic        wr_ptr_reg;
   logic [31:0] pc_mem [2];
   logic [31:0] ins_mem [2];
   logic        push;
   logic        pop;

   // The request is issued straight out of IDLE so a 1-cycle memory sustains
   // one instruction every two cycles; capacity counts the outstanding read.
   always_comb begin
      out_valid       = (count_reg != 2'd0) && !branch_taken;
      PC_out          = out_valid ? pc_mem[rd_ptr_reg] : 32'h0;
      Instruction_out = out_valid ? ins_mem[rd_ptr_reg] : NOP_INSTR;
      pop             = out_valid && !freeze;
      push            = (state_reg == WAIT) && imem_valid && !branch_taken;
      imem_rd_en      = !rst && (state_reg == IDLE) && !branch_taken && (count_reg != 2'd2);
      imem_addr       = (state_reg == IDLE) ? fetch_pc_reg : req_addr_reg;
   end

   assign buf_count = count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         req_addr_reg <= RESET_PC;
         count_reg    <= 2'd0;
         rd_ptr_reg   <= 1'b0;
         wr_ptr_reg   <= 1'b0;
      end else if (branch_taken) begin
         fetch_pc_reg <= branch_addr;
         count_reg    <= 2'd0;
         rd_ptr_reg   <= 1'b0;
         wr_ptr_reg   <= 1'b0;
         case (state_reg)
            WAIT, DISCARD: state_reg <= imem_valid ? IDLE : DISCARD;
            default:       state_reg <= IDLE;
         endcase
      end else begin
         case (state_reg)
            IDLE: begin
               if (imem_rd_en) begin
                  req_addr_reg <= fetch_pc_reg;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_valid) begin
                  fetch_pc_reg <= req_addr_reg + 32'd4;
                  state_reg    <= IDLE;
               end
            end
            DISCARD: begin
               if (imem_valid) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage needs no reset: out_valid masks it until a push lands.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]  <= req_addr_reg + 32'd4;
         ins_mem[wr_ptr_reg] <= imem_rdata;
      end
   end

endmodule
